// File: rtl/cla_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cla_seq_ctrl_pkg
// Shared definitions for the sequential carry-lookahead add/sub controller:
//   - state_e   : controller FSM states (IDLE, RUN, DONE)
//   - SLICE_W   : width of one carry-lookahead slice (4 bits)
//   - idx_width : width of the slice index for a given slice count (min 1)
// -----------------------------------------------------------------------------
package cla_seq_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // ceil(log2(slices)), never narrower than one bit so SLICES = 1 still
    // has a legal index register.
    function automatic int idx_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// cla_seq_ctrl_if
// Request/response bundle between a requester/consumer (master) and the
// cla_seq_ctrl controller (slave).
//   in_valid/in_ready   : operation handshake (a, b, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   busy                : controller is in RUN or DONE
// -----------------------------------------------------------------------------
interface cla_seq_ctrl_if #(
    parameter int SLICES = 4
);
    localparam int W = 4 * SLICES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

endinterface

// File: rtl/cla_seq_ctrl_cla4_slice.sv
// -----------------------------------------------------------------------------
// cla4_slice
// Purely combinational 4-bit carry-lookahead adder slice.
//   a, b : slice operands
//   cin  : carry in
//   sum  : slice sum
//   cout : slice carry out
// All internal carries are flattened generate/propagate terms, so no carry
// ripples bit to bit inside the slice.
// -----------------------------------------------------------------------------
module cla4_slice
    import cla_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:1]   c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ {c[3], c[2], c[1], cin};
    assign cout = c[4];

endmodule

// File: rtl/cla_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cla_seq_ctrl
// Sequential add/subtract unit: one 4-bit carry-lookahead slice is reused
// once per cycle, least significant nibble first, so a W = 4*SLICES bit
// operation takes SLICES cycles in RUN.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cla_seq_ctrl_if.slave
//           in_valid/in_ready/a/b/sub       operation request
//           out_valid/out_ready/sum/cout/ovf result
//           busy                            high in RUN or DONE
// Subtraction is done as A + ~B + 1: B is inverted on capture and the
// carry register is seeded with 1.
// -----------------------------------------------------------------------------
module cla_seq_ctrl
    import cla_seq_ctrl_pkg::*;
#(
    parameter int SLICES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_seq_ctrl_if.slave    bus
);

    localparam int                   W        = SLICE_W * SLICES;
    localparam int                   IDX_W    = idx_width(SLICES);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(SLICES - 1);

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;         // already inverted for subtraction
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               in_ready;
    logic               last_slice;
    logic [SLICE_W-1:0] a_nib, b_nib;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    assign last_slice = (idx_q == LAST_IDX);

    // ---------------------------------------------------------------- state
    // NOTE: every flop is written with <= so all registers sample the
    // pre-edge values of each other, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_d unassigned (which would infer a latch).
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid)  state_d = RUN;
            RUN:  if (last_slice)    state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        in_ready      = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
    end

    assign bus.in_ready = in_ready;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.ovf      = ovf_q;

    // ------------------------------------------------------ slice operands
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < SLICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*SLICE_W +: SLICE_W];
                b_nib = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    cla4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // ------------------------------------------------------------ datapath
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        if (in_ready && bus.in_valid) begin
            // Accept: previous result is dropped here, not at handoff.
            a_d     = bus.a;
            b_d     = bus.sub ? ~bus.b : bus.b;
            carry_d = bus.sub;
            idx_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < SLICES; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    sum_d[i*SLICE_W +: SLICE_W] = slice_sum;
                end
            end
            carry_d = slice_cout;
            if (last_slice) begin
                // Index saturates at the last slice; the top sum bit is the
                // one being written on this same edge.
                cout_d = slice_cout;
                ovf_d  = (a_q[W-1] == b_q[W-1]) &
                         (slice_sum[SLICE_W-1] != a_q[W-1]);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cla_seq_ctrl
// Self-checking bench for cla_seq_ctrl with SLICES = 4 (16-bit operands).
// Expected results come from a reference model using plain integer
// arithmetic: unsigned range for the carry/borrow, signed range for overflow.
// -----------------------------------------------------------------------------
module tb_cla_seq_ctrl;

    localparam int SLICES = 4;
    localparam int W      = 4 * SLICES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cla_seq_ctrl_if #(.SLICES(SLICES)) bus ();

    cla_seq_ctrl #(.SLICES(SLICES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic s);
        int ua;
        int ub;
        int sa;
        int sb;
        int ures;
        int sres;
        logic c;
        logic v;
        logic [W-1:0] r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!s) begin
            ures = ua + ub;
            sres = sa + sb;
            c    = (ures > 65535);
        end else begin
            ures = ua - ub;
            sres = sa - sb;
            c    = (ua >= ub);       // carry out of A-B means no borrow
        end
        r = ures[W-1:0];
        v = (sres > 32767) || (sres < -32768);
        return {v, c, r};
    endfunction

    // Starts between edges with the DUT idle; returns at a falling edge
    // with the DUT idle again.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic s, input int stall, input string tag);
        logic [W+1:0] exp;
        int edges;
        exp = model(av, bv, s);

        check($sformatf("%s.in_ready_idle", tag), bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.sub      = s;
        @(posedge clk);
        @(negedge clk);

        check($sformatf("%s.sum_cleared", tag), bus.sum, 0);
        check($sformatf("%s.busy_run", tag), bus.busy, 1);
        check($sformatf("%s.in_ready_run", tag), bus.in_ready, 0);

        // Keep requesting with garbage operands; the DUT must ignore them.
        bus.a   = 16'($urandom);
        bus.b   = 16'($urandom);
        bus.sub = 1'($urandom);

        edges = 1;
        while (bus.out_valid !== 1'b1 && edges < 4 * SLICES + 4) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        // The accept edge itself is edge 0 of the latency count.
        check($sformatf("%s.latency", tag), edges - 1, SLICES);
        check($sformatf("%s.sum", tag), bus.sum, exp[W-1:0]);
        check($sformatf("%s.cout", tag), bus.cout, exp[W]);
        check($sformatf("%s.ovf", tag), bus.ovf, exp[W+1]);

        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s.stall%0d.out_valid", tag, k), bus.out_valid, 1);
            check($sformatf("%s.stall%0d.in_ready", tag, k), bus.in_ready, 0);
            check($sformatf("%s.stall%0d.result", tag, k),
                  {bus.ovf, bus.cout, bus.sum}, exp);
        end

        // in_valid is still high across the handoff edge: no re-accept.
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check($sformatf("%s.post.out_valid", tag), bus.out_valid, 0);
        check($sformatf("%s.post.in_ready", tag), bus.in_ready, 1);
        check($sformatf("%s.post.busy", tag), bus.busy, 0);
        check($sformatf("%s.post.retained", tag),
              {bus.ovf, bus.cout, bus.sum}, exp);
    endtask

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst.in_ready", bus.in_ready, 1);
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.busy", bus.busy, 0);
        check("rst.result", {bus.ovf, bus.cout, bus.sum}, 0);

        // First accept lands on the first rising edge after release.
        rst_n = 1'b1;
        run_op(16'h1234, 16'h4321, 1'b0, 0, "add_basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1, "carry_ripple");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, "add_ovf");
        run_op(16'h8000, 16'h0001, 1'b1, 0, "sub_ovf");
        run_op(16'hABCD, 16'h1111, 1'b0, 3, "stall3");
        run_op(16'h0005, 16'h0009, 1'b1, 2, "sub_borrow");

        // Reset in the middle of 0x1111 + 0x2222 at idx = 2
        check("abort.in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.sub      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort.sum", bus.sum, 0);
        check("abort.out_valid", bus.out_valid, 0);
        check("abort.in_ready", bus.in_ready, 1);
        check("abort.busy", bus.busy, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        seen = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        bus.out_ready = 1'b0;
        check("abort.no_result", seen, 0);
        run_op(16'h0001, 16'h0001, 1'b0, 0, "after_reset");

        // Randomized operations against the model
        for (int n = 0; n < 24; n++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 Parameter SLICES, default 4, number of 4-bit slices per operand; operand width W = 4*SLICES.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  requester presents an operation.
REQ-005 in_ready  output  1  controller can accept an operation.
REQ-006 a  input  W  operand A, unsigned or two's complement.
REQ-007 b  input  W  operand B.
REQ-008 sub  input  1  0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 sum  output  W  result.
REQ-012 cout  output  1  final carry out (add: carry; sub: 1 = no borrow).
REQ-013 ovf  output  1  signed two's-complement overflow.
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; a transfer occurs on an edge where in_valid & in_ready = 1.
REQ-017 On a transfer, the block SHALL capture a, b (inverted when sub=1) and sub, set carry = sub, set slice index = 0 and go to RUN.
REQ-018 Each RUN cycle SHALL add nibble[idx] of captured A and B' plus carry through one 4-bit carry-lookahead slice.
REQ-019 On that edge, the block SHALL write the slice sum into sum[4*idx+3:4*idx], load the slice carry-out into carry and increment idx.
REQ-020 When idx = SLICES-1, the RUN edge SHALL go to DONE with cout = final carry.
REQ-021 Latency SHALL be exactly SLICES edges from the accept edge to out_valid = 1.
REQ-022 ovf SHALL equal (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1]).
REQ-023 out_valid SHALL be 1 only in DONE.
REQ-024 sum, cout and ovf SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-025 An edge with out_valid & out_ready = 1 SHALL go to IDLE.
REQ-026 There SHALL be no same-edge re-accept; in_ready rises the cycle after the result handoff.
REQ-027 in_valid and operand changes SHALL be ignored in RUN and DONE.
REQ-028 sum, cout and ovf SHALL retain the last result in IDLE until the next accept, which clears sum, cout and ovf to 0.
REQ-029 Index arithmetic SHALL use ceil(log2(SLICES)) bits (minimum 1) with no wrap past SLICES-1.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, idx = 0, carry = 0, sum = 0, cout = 0, ovf = 0, out_valid = 0 and busy = 0.
REQ-031 in_ready SHALL be 1 while rst_n is low.
REQ-032 Reset during RUN or DONE SHALL abandon the operation with no result delivered.
REQ-033 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the slice width constant (4).
REQ-035 One combinational sub-module, cla4_slice, SHALL implement the 4-bit carry-lookahead (generate/propagate, cin → sum[3:0], cout), instantiated once and reused every RUN cycle.

Verification (SLICES = 4)
REQ-036 0x1234 + 0x4321, sub = 0 -> sum 0x5555, cout 0, ovf 0; out_valid exactly 4 edges after accept.
REQ-037 0xFFFF + 0x0001 -> sum 0x0000, cout 1, ovf 0 (carry ripples through all four slices).
REQ-038 0x7FFF + 0x0001 -> sum 0x8000, cout 0, ovf 1; 0x8000 - 0x0001 (sub = 1) -> sum 0x7FFF, cout 1, ovf 1.
REQ-039 out_ready held low for 3 cycles in DONE -> out_valid stays 1, outputs unchanged, in_ready 0, new in_valid ignored; handoff, then in_ready = 1 next cycle.
REQ-040 rst_n pulsed low at idx = 2 of 0x1111 + 0x2222 -> immediately sum 0, out_valid 0, in_ready 1; no result emitted; next op 0x0001 + 0x0001 -> 0x0002.
